// File: rtl/gpio_ex_if.sv
// Request/response bus between a bus master and the gpio_ex slave.
// Signal names carry the slave-side direction suffix.
//   addr_i      register address (bits [4:2] decoded by the slave)
//   data_i      write data
//   sel_i       byte enables for writes
//   we_i        1=write, 0=read
//   req_valid_i request valid
//   req_ready_o request accepted when req_valid_i & req_ready_o
//   rsp_valid_o response valid
//   rsp_ready_i response consumed when rsp_valid_o & rsp_ready_i
//   data_o      read data, stable while rsp_valid_o=1
interface gpio_ex_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] data_o;

    modport master (
        output addr_i, data_i, sel_i, we_i, req_valid_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, data_o
    );

    modport slave (
        input  addr_i, data_i, sel_i, we_i, req_valid_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, data_o
    );
endinterface

// File: rtl/gpio_ex.sv
// GPIO peripheral with GPIO_NUM pins (input / push-pull / open-drain), synchronised
// inputs and per-pin selectable edge interrupts OR-ed onto one level interrupt.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus          request/response register port (slave side)
//   io_pin_i     raw pin levels
//   io_out_o     pin drive value
//   io_oe_o      pin output enable (tristate buffer lives outside)
//   int_sig_o    registered |(INT_PEND & INT_EN)
//
// Response FSM
//   state  | meaning
//   S_IDLE | no response outstanding
//   S_RESP | response valid, waiting for rsp_ready_i
module gpio_ex #(
    parameter int GPIO_NUM    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    gpio_ex_if.slave            bus,
    input  logic [GPIO_NUM-1:0] io_pin_i,
    output logic [GPIO_NUM-1:0] io_out_o,
    output logic [GPIO_NUM-1:0] io_oe_o,
    output logic                int_sig_o
);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_DATA     = 3'd1;
    localparam logic [2:0] A_INT_EN   = 3'd2;
    localparam logic [2:0] A_INT_TYPE = 3'd3;
    localparam logic [2:0] A_INT_PEND = 3'd4;

    state_t                  state_q, state_d;
    logic [2*GPIO_NUM-1:0]   ctrl;
    logic [GPIO_NUM-1:0]     dout;
    logic [GPIO_NUM-1:0]     int_en;
    logic [GPIO_NUM-1:0]     int_type;
    logic [GPIO_NUM-1:0]     int_pend;
    logic [GPIO_NUM-1:0]     sync_ff [SYNC_STAGES];
    logic [GPIO_NUM-1:0]     sync;
    logic [GPIO_NUM-1:0]     prev;
    logic [GPIO_NUM-1:0]     rise, fall, pend_set, pend_clr;
    logic [31:0]             wmask, wr_val, wr_keep, rd_data;
    logic [2:0]              reg_sel;
    logic                    accept, wr_en;
    logic                    unused_addr;

    assign reg_sel     = bus.addr_i[4:2];
    assign unused_addr = ^{bus.addr_i[31:5], bus.addr_i[1:0]};

    // ---------------- handshake ----------------
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.req_ready_o = (state_q == S_IDLE) | bus.rsp_ready_i;
    assign accept          = bus.req_valid_i & bus.req_ready_o;
    assign wr_en           = accept & bus.we_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = S_RESP;
        end else if (state_q == S_RESP && bus.rsp_ready_i) begin
            state_d = S_IDLE;
        end
    end

    // Read data is captured on acceptance and held for the whole response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_o <= '0;
        end else if (accept) begin
            bus.data_o <= bus.we_i ? 32'd0 : rd_data;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            A_CTRL:     rd_data[2*GPIO_NUM-1:0] = ctrl;
            A_DATA:     rd_data[GPIO_NUM-1:0]   = sync;
            A_INT_EN:   rd_data[GPIO_NUM-1:0]   = int_en;
            A_INT_TYPE: rd_data[GPIO_NUM-1:0]   = int_type;
            A_INT_PEND: rd_data[GPIO_NUM-1:0]   = int_pend;
            default:    rd_data = '0;
        endcase
    end

    // ---------------- register file ----------------
    assign wmask   = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}}, {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
    assign wr_val  = bus.data_i & wmask;
    assign wr_keep = ~wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            dout     <= '0;
            int_en   <= '0;
            int_type <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                A_CTRL:     ctrl     <= (ctrl & wr_keep[2*GPIO_NUM-1:0]) | wr_val[2*GPIO_NUM-1:0];
                A_DATA:     dout     <= (dout & wr_keep[GPIO_NUM-1:0]) | wr_val[GPIO_NUM-1:0];
                A_INT_EN:   int_en   <= (int_en & wr_keep[GPIO_NUM-1:0]) | wr_val[GPIO_NUM-1:0];
                A_INT_TYPE: int_type <= (int_type & wr_keep[GPIO_NUM-1:0]) | wr_val[GPIO_NUM-1:0];
                default: ;
            endcase
        end
    end

    // ---------------- pin drive ----------------
    always_comb begin
        io_oe_o  = '0;
        io_out_o = '0;
        for (int i = 0; i < GPIO_NUM; i++) begin
            case (ctrl[2*i +: 2])
                2'b01: begin
                    io_oe_o[i]  = 1'b1;
                    io_out_o[i] = dout[i];
                end
                2'b10:   io_oe_o[i] = ~dout[i];  // open-drain: only ever pull low
                default: ;
            endcase
        end
    end

    // ---------------- input synchroniser and edge detect ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= '0;
            end
            prev <= '0;
        end else begin
            sync_ff[0] <= io_pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
            prev <= sync;
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

    // ---------------- interrupts ----------------
    assign pend_set = ((int_type & fall) | (~int_type & rise)) & int_en;
    assign pend_clr = (wr_en && reg_sel == A_INT_PEND) ? wr_val[GPIO_NUM-1:0] : '0;

    // A new edge wins over a simultaneous write-1-to-clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_pend  <= '0;
            int_sig_o <= 1'b0;
        end else begin
            int_pend  <= (int_pend & ~pend_clr) | pend_set;
            int_sig_o <= |(int_pend & int_en);
        end
    end

endmodule
